// File: rtl/mdu_iter.sv
// mdu_iter - iterative RV32M multiply/divide unit.
//
// Executes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation at a time.
// Multiplies use radix-2 shift-add and divides use restoring division. Both
// work on operand magnitudes, one bit per cycle over 32 cycles, and the sign
// is applied when the unit enters DONE. Divide-by-zero and signed overflow
// bypass the iteration and finish one cycle after accept.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   md_valid         operation offered by ID/EX (accepted only when idle)
//   md_op            funct3 of the M-extension instruction
//   md_rs1_data      operand A (dividend / multiplicand)
//   md_rs2_data      operand B (divisor / multiplier)
//   md_rd            destination register index
//   busy_to_stall    unit owns an operation
//   finish_to_stall  one-cycle result-valid pulse
//   rd_to_stall      rd of the in-flight / last operation
//   md_result        result, held until the next operation completes
//   md_wb_en         finish with a non-zero rd
//
// Optional feature macro: ZCRV_MDU_FAST_MUL_EN
//   When defined, the four multiply ops use a single-cycle multiplier and
//   complete one cycle after accept. Divides are unaffected.

`ifndef ZCRV_REG_SIZE
`define ZCRV_REG_SIZE 5
`endif

module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      md_valid,
    input  logic [2:0]                md_op,
    input  logic [XLEN-1:0]           md_rs1_data,
    input  logic [XLEN-1:0]           md_rs2_data,
    input  logic [`ZCRV_REG_SIZE-1:0] md_rd,
    output logic                      busy_to_stall,
    output logic                      finish_to_stall,
    output logic [`ZCRV_REG_SIZE-1:0] rd_to_stall,
    output logic [XLEN-1:0]           md_result,
    output logic                      md_wb_en
);

    localparam int RW = `ZCRV_REG_SIZE;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [2:0]          op_r;
    logic                a_neg_r, b_neg_r;
    logic [XLEN-1:0]     opb_r;          // multiplicand for MUL, divisor for DIV
    logic [2*XLEN-1:0]   acc_r;          // {hi, lo}: product or {remainder, quotient}
    logic [RW-1:0]       rd_r;
    logic [XLEN-1:0]     result_r;
    logic                busy_r, finish_r, wb_en_r;

    logic                accept_s, skip_s, fast_s;
    logic                a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s;
    logic                div_zero_s, div_ovf_s;
    logic [XLEN-1:0]     fast_res_s, acc_res_s, calc_res_s, result_nxt_s;
    logic [XLEN:0]       add_s, shl_s, sub_s;
    logic                ge_s;
    logic [2*XLEN-1:0]   iter_s, prod_fix_s;
    logic [XLEN-1:0]     quo_fix_s, rem_fix_s;
    logic [RW-1:0]       rd_nxt_s;

    assign accept_s = md_valid && (state_r == ST_IDLE);

    // Operand signedness and magnitudes for the incoming operation.
    always_comb begin
        a_sgn_s    = (md_op == OP_MULH) || (md_op == OP_MULHSU) ||
                     (md_op == OP_DIV)  || (md_op == OP_REM);
        b_sgn_s    = (md_op == OP_MULH) || (md_op == OP_DIV) || (md_op == OP_REM);
        a_neg_s    = a_sgn_s && md_rs1_data[XLEN-1];
        b_neg_s    = b_sgn_s && md_rs2_data[XLEN-1];
        a_mag_s    = a_neg_s ? (-md_rs1_data) : md_rs1_data;
        b_mag_s    = b_neg_s ? (-md_rs2_data) : md_rs2_data;
        div_zero_s = md_op[2] && (md_rs2_data == {XLEN{1'b0}});
        div_ovf_s  = ((md_op == OP_DIV) || (md_op == OP_REM)) &&
                     (md_rs1_data == INT_MIN) && (md_rs2_data == ALL_ONES);
    end

`ifdef ZCRV_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fa_s, fb_s, fprod_s;

    // Single-cycle multiply; low 64 bits of the sign-extended product are
    // exact for every multiply variant.
    always_comb begin
        fa_s       = {{XLEN{a_sgn_s && md_rs1_data[XLEN-1]}}, md_rs1_data};
        fb_s       = {{XLEN{b_sgn_s && md_rs2_data[XLEN-1]}}, md_rs2_data};
        fprod_s    = fa_s * fb_s;
        fast_s     = !md_op[2];
        fast_res_s = (md_op == OP_MUL) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
    end
`else
    assign fast_s     = 1'b0;
    assign fast_res_s = {XLEN{1'b0}};
`endif

    assign skip_s = div_zero_s || div_ovf_s || fast_s;

    // Result for operations that finish straight from the accept edge.
    always_comb begin
        acc_res_s = {XLEN{1'b0}};
        if (div_zero_s) begin
            acc_res_s = ((md_op == OP_DIV) || (md_op == OP_DIVU)) ? ALL_ONES : md_rs1_data;
        end else if (div_ovf_s) begin
            acc_res_s = (md_op == OP_DIV) ? INT_MIN : {XLEN{1'b0}};
        end else begin
            acc_res_s = fast_res_s;
        end
    end

    // One shift-add or restoring-divide step on the accumulator.
    always_comb begin
        add_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        shl_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        ge_s  = (shl_s >= {1'b0, opb_r});
        sub_s = shl_s - {1'b0, opb_r};
        if (op_r[2]) begin
            iter_s = {(ge_s ? sub_s[XLEN-1:0] : shl_s[XLEN-1:0]), acc_r[XLEN-2:0], ge_s};
        end else begin
            iter_s = {add_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection on the final iteration.
    always_comb begin
        prod_fix_s = (a_neg_r ^ b_neg_r) ? (-iter_s) : iter_s;
        quo_fix_s  = (a_neg_r ^ b_neg_r) ? (-iter_s[XLEN-1:0]) : iter_s[XLEN-1:0];
        rem_fix_s  = a_neg_r ? (-iter_s[2*XLEN-1:XLEN]) : iter_s[2*XLEN-1:XLEN];
        case (op_r)
            OP_MUL:                        calc_res_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  calc_res_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               calc_res_s = quo_fix_s;
            OP_REM, OP_REMU:               calc_res_s = rem_fix_s;
            default:                       calc_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state, counter and result selection.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        result_nxt_s = result_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                if (md_valid) begin
                    if (skip_s) begin
                        state_nxt_s  = ST_DONE;
                        result_nxt_s = acc_res_s;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s  = ST_DONE;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    result_nxt_s = calc_res_s;
                end else begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
        rd_nxt_s = accept_s ? md_rd : rd_r;
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {XLEN{1'b0}};
            rd_r     <= {RW{1'b0}};
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
            wb_en_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            result_r <= result_nxt_s;
            rd_r     <= rd_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            finish_r <= (state_nxt_s == ST_DONE);
            wb_en_r  <= (state_nxt_s == ST_DONE) && (rd_nxt_s != {RW{1'b0}});
        end
    end

    // Operand latch on accept, accumulator update while iterating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= 3'd0;
            a_neg_r <= 1'b0;
            b_neg_r <= 1'b0;
            opb_r   <= {XLEN{1'b0}};
            acc_r   <= {(2*XLEN){1'b0}};
        end else if (accept_s) begin
            op_r    <= md_op;
            a_neg_r <= a_neg_s;
            b_neg_r <= b_neg_s;
            opb_r   <= md_op[2] ? b_mag_s : a_mag_s;
            acc_r   <= {{XLEN{1'b0}}, (md_op[2] ? a_mag_s : b_mag_s)};
        end else if (state_r == ST_CALC) begin
            acc_r <= iter_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign busy_to_stall   = busy_r;
    assign finish_to_stall = finish_r;
    assign rd_to_stall     = rd_r;
    assign md_result       = result_r;
    assign md_wb_en        = wb_en_r;

endmodule
